// File: rtl/sync_fifo_reader_if.sv
// rtl/sync_fifo_reader_if.sv - valid/ready output stream of the sync FIFO read drain engine
interface sync_fifo_reader_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  m_valid;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_ready;

   modport master (output m_valid, output m_data, input m_ready);
   modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/sync_fifo_reader.sv
// rtl/sync_fifo_reader.sv - drains a sync FIFO (1-cycle read latency) into a valid/ready stream
// Optional beat counter: define SYNC_FIFO_RD_STATS_EN.
module sync_fifo_reader #(
   parameter int DATA_WIDTH = 8
`ifdef SYNC_FIFO_RD_STATS_EN
   ,
   parameter int CNT_WIDTH  = 16
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  drain_en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   output logic                  fifo_read_en,
`ifdef SYNC_FIFO_RD_STATS_EN
   output logic [CNT_WIDTH-1:0]  beat_count,
`endif
   sync_fifo_reader_if.master    m
);
   localparam logic [2:0] DEPTH = 3'd3;

   logic [DATA_WIDTH-1:0] q     [3];
   logic [DATA_WIDTH-1:0] q_nxt [3];
   logic [1:0]            buf_cnt;
   logic [1:0]            buf_cnt_nxt;
   logic                  rd_pending;
   logic                  pop;

   assign m.m_valid = (buf_cnt != 2'd0);
   assign m.m_data  = q[0];
   assign pop       = m.m_valid && m.m_ready;

   // Credit counts the in-flight read so a word always has a slot; m_ready is never consulted.
   assign fifo_read_en = !reset && drain_en && !fifo_empty &&
                         (({1'b0, buf_cnt} + {2'b00, rd_pending}) < DEPTH);

   always_comb begin
      q_nxt       = q;
      buf_cnt_nxt = buf_cnt;
      if (pop) begin
         q_nxt[0]    = q[1];
         q_nxt[1]    = q[2];
         buf_cnt_nxt = buf_cnt - 2'd1;
      end
      if (rd_pending) begin
         for (int i = 0; i < 3; i++) begin
            if (2'(i) == buf_cnt_nxt) q_nxt[i] = fifo_rdata;
         end
         buf_cnt_nxt = buf_cnt_nxt + 2'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q          <= '{default: '0};
         buf_cnt    <= 2'd0;
         rd_pending <= 1'b0;
      end else begin
         q          <= q_nxt;
         buf_cnt    <= buf_cnt_nxt;
         rd_pending <= fifo_read_en;
      end
   end

`ifdef SYNC_FIFO_RD_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         beat_count <= '0;
      else if (pop)
         beat_count <= beat_count + CNT_WIDTH'(1);
   end
`endif

   overflow_check: assert property (@(posedge clk) disable iff (reset)
      ({1'b0, buf_cnt} + {2'b00, rd_pending}) <= DEPTH);

endmodule

// File: tb/tb_sync_fifo_reader.sv
// tb/tb_sync_fifo_reader.sv - self-checking bench for sync_fifo_reader with a queue-based reference model
module tb_sync_fifo_reader;
   logic       clk = 1'b0;
   logic       reset;
   logic       drain_en;
   logic       fifo_empty;
   logic       fifo_read_en;
   logic [7:0] fifo_rdata;
`ifdef SYNC_FIFO_RD_STATS_EN
   logic [15:0] beat_count;
`endif

   sync_fifo_reader_if #(.DATA_WIDTH(8)) st ();

   sync_fifo_reader #(.DATA_WIDTH(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .drain_en     (drain_en),
      .fifo_empty   (fifo_empty),
      .fifo_rdata   (fifo_rdata),
      .fifo_read_en (fifo_read_en),
`ifdef SYNC_FIFO_RD_STATS_EN
      .beat_count   (beat_count),
`endif
      .m            (st)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [7:0] fq[$];
   logic [7:0] exp_out[$];
   bit         force_empty;
   bit         rd_last;

   logic [7:0] mq[$];
   bit         m_pend;
   logic [7:0] m_pend_word;
   int         beats;

   logic       s_re;
   logic       s_v;
   logic [7:0] s_d;

   typedef struct {
      int         load_n;
      bit         dr;
      bit         rdy;
      bit         re;
      bit         v;
      logic [7:0] d;
   } vec_t;
   vec_t tbl[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // FIFO model: a read issued at a rising edge shows its word from the following falling edge.
   task automatic step(input bit dr, input bit rdy);
      @(negedge clk);
      if (rd_last && fq.size() > 0) fifo_rdata = fq.pop_front();
      fifo_empty  = force_empty || (fq.size() == 0);
      drain_en    = dr;
      st.m_ready  = rdy;
      #1;
      s_re    = fifo_read_en;
      s_v     = st.m_valid;
      s_d     = st.m_data;
      rd_last = s_re;
   endtask

   task automatic load(input logic [7:0] first, input int n);
      for (int k = 0; k < n; k++) begin
         fq.push_back(first + 8'(k));
         exp_out.push_back(first + 8'(k));
      end
   endtask

   task automatic model_check(input string tag);
      bit         exp_re;
      logic [7:0] want;
      exp_re = drain_en && !fifo_empty && ((mq.size() + int'(m_pend)) < 3);
      check({tag, " read_en"}, 32'(s_re), 32'(exp_re));
      check({tag, " m_valid"}, 32'(s_v), 32'(mq.size() != 0));
      if (mq.size() != 0) check({tag, " m_data"}, 32'(s_d), 32'(mq[0]));
      if (s_v && st.m_ready) begin
         want = (exp_out.size() != 0) ? exp_out.pop_front() : ~s_d;
         check({tag, " beat order"}, 32'(s_d), 32'(want));
      end
      if (mq.size() != 0 && st.m_ready) begin
         void'(mq.pop_front());
         beats++;
      end
      if (m_pend) mq.push_back(m_pend_word);
      m_pend = exp_re;
      if (exp_re && fq.size() != 0) m_pend_word = fq[0];
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("async rst read_en", 32'(fifo_read_en), 32'd0);
      check("async rst m_valid", 32'(st.m_valid), 32'd0);
      check("async rst m_data", 32'(st.m_data), 32'd0);
      drain_en    = 1'b0;
      st.m_ready  = 1'b0;
      fq.delete();
      exp_out.delete();
      mq.delete();
      m_pend      = 1'b0;
      rd_last     = 1'b0;
      beats       = 0;
      force_empty = 1'b0;
      fifo_empty  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int re_n, v_n, first_v, last_v, last_re, obs, re_win;
      reset       = 1'b0;
      drain_en    = 1'b0;
      fifo_empty  = 1'b1;
      fifo_rdata  = 8'h00;
      st.m_ready  = 1'b0;
      force_empty = 1'b0;
      rd_last     = 1'b0;
      m_pend      = 1'b0;
      m_pend_word = 8'h00;
      beats       = 0;

      #2 reset = 1'b1;
      #1;
      check("reset read_en", 32'(fifo_read_en), 32'd0);
      check("reset m_valid", 32'(st.m_valid), 32'd0);
      check("reset m_data", 32'(st.m_data), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      tbl[0] = '{0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      tbl[1] = '{2, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
      tbl[2] = '{0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
      tbl[3] = '{0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11};
      tbl[4] = '{0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22};
      tbl[5] = '{0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22};
      tbl[6] = '{0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22};
      tbl[7] = '{0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < tbl[i].load_n; k++) fq.push_back(8'(8'h11 * (k + 1)));
         step(tbl[i].dr, tbl[i].rdy);
         check($sformatf("vec%0d read_en", i), 32'(s_re), 32'(tbl[i].re));
         check($sformatf("vec%0d m_valid", i), 32'(s_v), 32'(tbl[i].v));
         if (tbl[i].v) check($sformatf("vec%0d m_data", i), 32'(s_d), 32'(tbl[i].d));
      end

      // Full-rate drain of 16 preloaded words
      do_reset();
      load(8'h01, 16);
      re_n = 0; v_n = 0; first_v = -1; last_v = -1; last_re = -1;
      for (int c = 0; c < 20; c++) begin
         step(1'b1, 1'b1);
         model_check("t2");
         if (s_re) begin re_n++; last_re = c; end
         if (s_v) begin
            if (first_v < 0) first_v = c;
            last_v = c;
            v_n++;
         end
      end
      check("t2 read count", re_n, 16);
      check("t2 last read cycle", last_re, 15);
      check("t2 first valid cycle", first_v, 2);
      check("t2 last valid cycle", last_v, 17);
      check("t2 valid cycles", v_n, 16);
`ifdef SYNC_FIFO_RD_STATS_EN
      check("t2 beat_count", 32'(beat_count), 32'd16);
`endif

      // Backpressure from cycle 3 for 10 cycles
      do_reset();
      load(8'h01, 16);
      for (int c = 0; c < 34; c++) begin
         step(1'b1, !(c >= 3 && c < 13));
         model_check("t3");
         if (c == 12) begin
            check("t3 held m_data", 32'(s_d), 32'h02);
            check("t3 held m_valid", 32'(s_v), 32'd1);
            check("t3 read stalled", 32'(s_re), 32'd0);
         end
      end
      check("t3 all delivered", exp_out.size(), 0);

      // FIFO reports empty: no reads at all
      do_reset();
      load(8'h40, 4);
      force_empty = 1'b1;
      re_n = 0; v_n = 0;
      for (int c = 0; c < 20; c++) begin
         step(1'b1, 1'b1);
         model_check("t4");
         if (s_re) re_n++;
         if (s_v) v_n++;
      end
      check("t4 reads while empty", re_n, 0);
      check("t4 valid while empty", v_n, 0);
      force_empty = 1'b0;

      // drain_en pause in cycles 6..13
      do_reset();
      load(8'h01, 16);
      obs = 0; re_win = 0;
      for (int c = 0; c < 40; c++) begin
         step(!(c >= 6 && c < 14), 1'b1);
         model_check("t5");
         if (s_v) obs++;
         if (c >= 6 && c < 14 && s_re) re_win++;
         if (c == 13) begin
            check("t5 idle after pause", 32'(s_v), 32'd0);
            check("t5 beats before resume", obs, 6);
         end
      end
      check("t5 reads in pause", re_win, 0);
      check("t5 all delivered", exp_out.size(), 0);

      // Reset in cycle 5 of a full-rate drain, then a fresh 4-word load
      do_reset();
      load(8'h01, 16);
      for (int c = 0; c < 5; c++) begin
         step(1'b1, 1'b1);
         model_check("t6 pre");
      end
      do_reset();
      load(8'hA0, 4);
      obs = 0;
      for (int c = 0; c < 10; c++) begin
         step(1'b1, 1'b1);
         model_check("t6");
         if (s_v) obs++;
      end
      check("t6 beats after reset", obs, 4);
      check("t6 all delivered", exp_out.size(), 0);
`ifdef SYNC_FIFO_RD_STATS_EN
      check("t6 beat_count", 32'(beat_count), 32'd4);
`endif

      // Random traffic against the model
      do_reset();
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(3) == 0) begin
            for (int k = 0; k < int'($urandom_range(3, 1)); k++) begin
               logic [7:0] w;
               w = 8'($urandom);
               fq.push_back(w);
               exp_out.push_back(w);
            end
         end
         force_empty = ($urandom_range(9) == 0);
         step($urandom_range(7) != 0, $urandom_range(3) != 0);
         model_check("rnd");
      end
      force_empty = 1'b0;
      for (int c = 0; c < 2000 && exp_out.size() != 0; c++) begin
         step(1'b1, 1'b1);
         model_check("rnd drain");
      end
      check("rnd all delivered", exp_out.size(), 0);
`ifdef SYNC_FIFO_RD_STATS_EN
      check("rnd beat_count", 32'(beat_count), 32'(beats));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
